// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: mode encodings and
// default parameter values used by pc_sequencer and return_stack.
package pc_pkg;

  // Default parameter values
  localparam int unsigned PC_WIDTH_DEF        = 16;
  localparam int unsigned PC_INC_DEF          = 2;
  localparam int unsigned STACK_DEPTH_DEF     = 8;
  localparam int unsigned PC_RESET_VECTOR_DEF = 0;

  // Sequencer operation selected by the Mode input
  typedef enum logic [1:0] {
    MODE_SEQ  = 2'b00,
    MODE_JUMP = 2'b01,
    MODE_CALL = 2'b10,
    MODE_RET  = 2'b11
  } mode_e;

endpackage : pc_pkg

// File: rtl/return_stack.sv
// Return-address stack. Owns the storage and the entry count. The top of
// stack is presented combinationally on dout; entries at or above the count
// are never shown (dout reads zero while empty).
module return_stack
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH_DEF,
  parameter int unsigned DEPTH = STACK_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    top_cnt;

  // Guard against pushing into a full stack or popping an empty one; a
  // simultaneous request is treated as a push.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !push && !empty;
  end

  // Storage write at the slot just above the current top
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[count[AW-1:0]] <= din;
    end
  end

  // Entry count, bounded to 0..DEPTH by the guards above
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (do_push) begin
      count <= count + CW'(1);
    end else if (do_pop) begin
      count <= count - CW'(1);
    end
  end

  // Status decode and top-of-stack read from the registered count
  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    top_cnt = count - CW'(1);
    dout    = empty ? '0 : mem[top_cnt[AW-1:0]];
  end

endmodule : return_stack

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with call/return stack. Owns the PC register,
// the mode decode and the sticky overflow/underflow flags; the return
// addresses live in return_stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned       WIDTH        = PC_WIDTH_DEF,
  parameter int unsigned       INC          = PC_INC_DEF,
  parameter int unsigned       DEPTH        = STACK_DEPTH_DEF,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(PC_RESET_VECTOR_DEF)
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             PCWrite,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] PCIn,
  input  logic             ErrClear,
  output logic [WIDTH-1:0] PCout,
  output logic             StackEmpty,
  output logic             StackFull,
  output logic             Overflow,
  output logic             Underflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  mode_e            mode;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_inc;
  logic             ovf_q;
  logic             unf_q;
  logic             ovf_set;
  logic             unf_set;
  logic             stk_push;
  logic             stk_pop;
  logic [WIDTH-1:0] stk_dout;
  logic [CW-1:0]    stk_count;
  logic             stk_empty;
  logic             stk_full;

  assign mode   = mode_e'(Mode);
  assign pc_inc = pc_q + WIDTH'(INC);

  return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (CLK),
    .rst_n (Reset_n),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_inc),
    .dout  (stk_dout),
    .count (stk_count),
    .empty (stk_empty),
    .full  (stk_full)
  );

  // Mode decode: next PC, stack requests and error detection
  always_comb begin
    pc_d     = pc_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    if (PCWrite) begin
      case (mode)
        MODE_SEQ:  pc_d = pc_inc;
        MODE_JUMP: pc_d = PCIn;
        MODE_CALL: begin
          if (stk_full) begin
            ovf_set = 1'b1;
          end else begin
            stk_push = 1'b1;
            pc_d     = PCIn;
          end
        end
        MODE_RET: begin
          if (stk_empty) begin
            unf_set = 1'b1;
          end else begin
            stk_pop = 1'b1;
            pc_d    = stk_dout;
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  // PC register
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Sticky error flags; a new error on the clearing edge wins
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (ErrClear) begin
        ovf_q <= 1'b0;
      end
      if (unf_set) begin
        unf_q <= 1'b1;
      end else if (ErrClear) begin
        unf_q <= 1'b0;
      end
    end
  end

  // Status outputs straight from registered state
  always_comb begin
    PCout      = pc_q;
    StackEmpty = (stk_count == '0);
    StackFull  = (stk_count == CW'(DEPTH));
    Overflow   = ovf_q;
    Underflow  = unf_q;
  end

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (default parameters).
module tb_pc_sequencer;
  import pc_pkg::*;

  logic        CLK;
  logic        Reset_n;
  logic        PCWrite;
  logic [1:0]  Mode;
  logic [15:0] PCIn;
  logic        ErrClear;
  logic [15:0] PCout;
  logic        StackEmpty;
  logic        StackFull;
  logic        Overflow;
  logic        Underflow;

  pc_sequencer #(
    .WIDTH        (16),
    .INC          (2),
    .DEPTH        (8),
    .RESET_VECTOR (16'h0000)
  ) dut (
    .CLK        (CLK),
    .Reset_n    (Reset_n),
    .PCWrite    (PCWrite),
    .Mode       (Mode),
    .PCIn       (PCIn),
    .ErrClear   (ErrClear),
    .PCout      (PCout),
    .StackEmpty (StackEmpty),
    .StackFull  (StackFull),
    .Overflow   (Overflow),
    .Underflow  (Underflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] pc;
    logic        e;
    logic        f;
    logic        o;
    logic        u;
    string       name;
  } exp_t;

  typedef struct {
    logic        pw;
    logic [1:0]  mode;
    logic [15:0] pcin;
    logic        ec;
    exp_t        exp;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(input logic [15:0] pc, input logic e, input logic f,
                              input logic o, input logic u, input string name);
    exp_t r;
    r.pc = pc; r.e = e; r.f = f; r.o = o; r.u = u; r.name = name;
    return r;
  endfunction

  function automatic vec_t mv(input logic pw, input logic [1:0] md, input logic [15:0] pin,
                              input logic ec, input exp_t x);
    vec_t v;
    v.pw = pw; v.mode = md; v.pcin = pin; v.ec = ec; v.exp = x;
    return v;
  endfunction

  task automatic compare_next();
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got pc=%h, no expectation queued", PCout);
    end else begin
      x = sb.pop_front();
      if (PCout !== x.pc || StackEmpty !== x.e || StackFull !== x.f ||
          Overflow !== x.o || Underflow !== x.u) begin
        errors++;
        $display("FAIL %s: got pc=%h e=%b f=%b o=%b u=%b, expected pc=%h e=%b f=%b o=%b u=%b",
                 x.name, PCout, StackEmpty, StackFull, Overflow, Underflow,
                 x.pc, x.e, x.f, x.o, x.u);
      end
    end
  endtask

  task automatic step(input logic pw, input logic [1:0] md, input logic [15:0] pin,
                      input logic ec, input exp_t x);
    PCWrite  = pw;
    Mode     = md;
    PCIn     = pin;
    ErrClear = ec;
    sb.push_back(x);
    @(posedge CLK);
    #1;
    compare_next();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ret_exp [8];
    logic [15:0] cur_pc;
    logic [15:0] tgt;

    Reset_n = 1'b0; PCWrite = 1'b0; Mode = MODE_SEQ; PCIn = '0; ErrClear = 1'b0;

    // Basic flow, errors, stall and wrap
    tbl.push_back(mv(1, MODE_SEQ,  16'h0000, 0, mk(16'h0002, 1, 0, 0, 0, "seq1")));
    tbl.push_back(mv(1, MODE_SEQ,  16'h0000, 0, mk(16'h0004, 1, 0, 0, 0, "seq2")));
    tbl.push_back(mv(1, MODE_SEQ,  16'h0000, 0, mk(16'h0006, 1, 0, 0, 0, "seq3")));
    tbl.push_back(mv(1, MODE_SEQ,  16'h0000, 0, mk(16'h0008, 1, 0, 0, 0, "seq4")));
    tbl.push_back(mv(1, MODE_JUMP, 16'h0010, 0, mk(16'h0010, 1, 0, 0, 0, "jump")));
    tbl.push_back(mv(1, MODE_CALL, 16'h0100, 0, mk(16'h0100, 0, 0, 0, 0, "call")));
    tbl.push_back(mv(1, MODE_SEQ,  16'h0000, 0, mk(16'h0102, 0, 0, 0, 0, "seq_in_sub")));
    tbl.push_back(mv(1, MODE_RET,  16'h0000, 0, mk(16'h0012, 1, 0, 0, 0, "ret")));
    tbl.push_back(mv(1, MODE_RET,  16'h0000, 0, mk(16'h0012, 1, 0, 0, 1, "ret_empty")));
    tbl.push_back(mv(0, MODE_RET,  16'h0000, 1, mk(16'h0012, 1, 0, 0, 0, "errclear")));
    tbl.push_back(mv(1, MODE_RET,  16'h0000, 1, mk(16'h0012, 1, 0, 0, 1, "clear_vs_set")));
    tbl.push_back(mv(0, MODE_SEQ,  16'h0000, 1, mk(16'h0012, 1, 0, 0, 0, "errclear2")));
    tbl.push_back(mv(0, MODE_CALL, 16'h0500, 0, mk(16'h0012, 1, 0, 0, 0, "stall1")));
    tbl.push_back(mv(0, MODE_CALL, 16'h0500, 0, mk(16'h0012, 1, 0, 0, 0, "stall2")));
    tbl.push_back(mv(0, MODE_CALL, 16'h0500, 0, mk(16'h0012, 1, 0, 0, 0, "stall3")));
    tbl.push_back(mv(1, MODE_JUMP, 16'hFFFE, 0, mk(16'hFFFE, 1, 0, 0, 0, "jump_top")));
    tbl.push_back(mv(1, MODE_SEQ,  16'h0000, 0, mk(16'h0000, 1, 0, 0, 0, "seq_wrap")));
    tbl.push_back(mv(1, MODE_JUMP, 16'hFFFC, 0, mk(16'hFFFC, 1, 0, 0, 0, "jump_fffc")));
    tbl.push_back(mv(1, MODE_CALL, 16'h0200, 0, mk(16'h0200, 0, 0, 0, 0, "call_near_top")));
    tbl.push_back(mv(1, MODE_RET,  16'h0000, 0, mk(16'hFFFE, 1, 0, 0, 0, "ret_near_top")));
    tbl.push_back(mv(1, MODE_SEQ,  16'h0000, 0, mk(16'h0000, 1, 0, 0, 0, "seq_wrap2")));

    // Reset state
    #12;
    sb.push_back(mk(16'h0000, 1, 0, 0, 0, "reset_state"));
    compare_next();
    @(negedge CLK);
    Reset_n = 1'b1;

    foreach (tbl[i]) step(tbl[i].pw, tbl[i].mode, tbl[i].pcin, tbl[i].ec, tbl[i].exp);

    // Nested calls up to full, overflow, then LIFO returns
    cur_pc = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      tgt        = 16'h1000 + 16'(i) * 16'h0100;
      ret_exp[i] = cur_pc + 16'h0002;
      step(1, MODE_CALL, tgt, 0, mk(tgt, 0, (i == 7), 0, 0, "call_nest"));
      cur_pc = tgt;
    end
    step(1, MODE_CALL, 16'h2000, 0, mk(16'h1700, 0, 1, 1, 0, "call_overflow"));
    step(1, MODE_CALL, 16'h2000, 1, mk(16'h1700, 0, 1, 1, 0, "ovf_clear_vs_set"));
    step(0, MODE_SEQ,  16'h0000, 1, mk(16'h1700, 0, 1, 0, 0, "ovf_clear"));
    for (int j = 0; j < 8; j++) begin
      step(1, MODE_RET, 16'h0000, 0, mk(ret_exp[7-j], (j == 7), 0, 0, 0, "ret_lifo"));
      if (j == 3) begin
        for (int k = 0; k < 3; k++)
          step(0, MODE_CALL, 16'h0700, 0, mk(ret_exp[4], 0, 0, 0, 0, "stall_nonempty"));
      end
    end

    // Asynchronous reset between edges after three calls
    step(1, MODE_RET,  16'h0000, 0, mk(16'h0002, 1, 0, 0, 1, "ret_empty2"));
    step(1, MODE_CALL, 16'h0400, 0, mk(16'h0400, 0, 0, 0, 1, "call_a"));
    step(1, MODE_CALL, 16'h0500, 0, mk(16'h0500, 0, 0, 0, 1, "call_b"));
    step(1, MODE_CALL, 16'h0600, 0, mk(16'h0600, 0, 0, 0, 1, "call_c"));
    @(negedge CLK);
    Reset_n = 1'b0;
    #1;
    sb.push_back(mk(16'h0000, 1, 0, 0, 0, "async_reset"));
    compare_next();

    // CALL presented while reset is held is discarded
    PCWrite = 1'b1; Mode = MODE_CALL; PCIn = 16'h3000; ErrClear = 1'b0;
    sb.push_back(mk(16'h0000, 1, 0, 0, 0, "reset_held"));
    @(posedge CLK);
    #1;
    compare_next();
    @(negedge CLK);
    Reset_n = 1'b1;
    sb.push_back(mk(16'h3000, 0, 0, 0, 0, "first_after_reset"));
    @(posedge CLK);
    #1;
    compare_next();
    step(1, MODE_RET, 16'h0000, 0, mk(16'h0002, 1, 0, 0, 0, "ret_after_reset"));

    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pc_sequencer

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 16: PC and address width in bits.
REQ-002 Parameter INC, default 2: sequential increment in address units.
REQ-003 Parameter DEPTH, default 8: return-address stack entries (DEPTH >= 2).
REQ-004 Parameter RESET_VECTOR, default 0: PC value at reset.
REQ-005 CLK  input  1: single clock; all state updates on the rising edge.
REQ-006 Reset_n  input  1: asynchronous, active-low reset.
REQ-007 PCWrite  input  1: advance enable; 0 = stall, no state changes.
REQ-008 Mode  input  2: 00 SEQ, 01 JUMP, 10 CALL, 11 RET.
REQ-009 PCIn  input  WIDTH: jump/call target.
REQ-010 ErrClear  input  1: clears the sticky error flags.
REQ-011 PCout  output  WIDTH: current PC, registered.
REQ-012 StackEmpty  output  1: stack holds 0 entries.
REQ-013 StackFull  output  1: stack holds DEPTH entries.
REQ-014 Overflow  output  1: sticky; a CALL was attempted while full.
REQ-015 Underflow  output  1: sticky; a RET was attempted while empty.

Function
REQ-016 PCWrite=0: PCout, stack contents, stack count and flags SHALL hold; ErrClear still acts.
REQ-017 SEQ with PCWrite=1: PCout <= (PCout + INC) mod 2^WIDTH on the next edge; 0xFFFE+2 wraps to 0x0000.
REQ-018 JUMP: PCout <= PCIn; stack unchanged.
REQ-019 CALL, not full: push (PCout + INC) mod 2^WIDTH, count+1, PCout <= PCIn; all in the same edge.
REQ-020 CALL while full: no push, PCout holds, Overflow <= 1.
REQ-021 RET, not empty: PCout <= top entry, count-1.
REQ-022 RET while empty: PCout holds, Underflow <= 1.
REQ-023 Latency: every update is visible on PCout one cycle after the enabling edge; no combinational path from inputs to PCout.
REQ-024 StackEmpty and StackFull SHALL be decoded from the registered count and track it in the same cycle.
REQ-025 ErrClear=1 clears both flags; if a new error occurs on the same edge, set wins.
REQ-026 Count width: clog2(DEPTH+1) bits; the count never exceeds DEPTH and never goes below 0.
REQ-027 Stack entries above the count are don't-care and SHALL NOT be observable.

Reset
REQ-028 Reset_n=0 SHALL immediately set PCout=RESET_VECTOR, count=0, StackEmpty=1, StackFull=0, Overflow=0, Underflow=0, regardless of CLK.
REQ-029 Reset asserted mid-sequence (e.g. during a CALL edge) SHALL discard the operation in progress; the first update after deassertion is taken at the first rising edge with Reset_n=1.
REQ-030 Stack storage need not be reset.

Structure
REQ-031 The shared package pc_pkg SHALL hold the Mode encodings (MODE_SEQ, MODE_JUMP, MODE_CALL, MODE_RET) and the default parameter values.
REQ-032 The stack SHALL be a separate sub-module, return_stack (parameters WIDTH, DEPTH; ports push, pop, din, dout, count, empty, full), instantiated once.
REQ-033 pc_sequencer SHALL own the PC register, the mode decode and the error flags; return_stack SHALL own storage and the count.

Verification
REQ-034 Reset, then 4 cycles of SEQ with PCWrite=1 -> PCout 0,2,4,6,8.
REQ-035 PC=0x0010, CALL with PCIn=0x0100, then SEQ, then RET -> PCout 0x0100, 0x0102, 0x0012; StackEmpty returns to 1.
REQ-036 DEPTH=8: 8 nested CALLs -> StackFull=1; 9th CALL -> PCout holds, Overflow=1; 8 RETs return the pushed addresses in LIFO order.
REQ-037 RET on an empty stack -> PCout holds, Underflow=1; ErrClear pulse -> 0; ErrClear together with another empty RET -> Underflow stays 1.
REQ-038 PCWrite=0 for 3 cycles with Mode=CALL -> no change in PCout or count; PC=0xFFFE with SEQ -> 0x0000.
REQ-039 Reset_n pulsed low between clock edges after 3 CALLs -> PCout=RESET_VECTOR and StackEmpty=1 immediately, before the next edge.
